// File: rtl/mixer_pkg.sv
// Shared types and default constants for the NCO mixer sequencing controller.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_e;

    localparam int PHI_W_DEF   = 16;
    localparam int LEN_W_DEF   = 24;
    localparam int DEF_PHI     = 8192;
    localparam int RST_CYC_DEF = 2;
    localparam int LED_DIV_DEF = 312500;

    // Settling time is the NCO pipeline latency plus one full mean-filter fill.
    localparam int MEAN_DEPTH     = 8;
    localparam int NCO_LAT        = 2;
    localparam int SETTLE_CYC_DEF = NCO_LAT + MEAN_DEPTH;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mixer_led_div.sv
// Heartbeat divider: toggles led_o once every LED_DIV cycles with valid_i high.
module mixer_led_div #(
    parameter int LED_DIV = 312500
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic led_o
);

    localparam int CNT_W = $clog2(LED_DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else if (valid_i) begin
            if (cnt_q == CNT_W'(LED_DIV - 1)) begin
                cnt_q <= '0;
                led_q <= ~led_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/mixer_ctrl.sv
// Mixer sequencing controller: NCO load/settle/run sequencing with valid/ready tuning.
// Optional heartbeat LED divider is built when MIXER_CTRL_LED_EN is defined.
module mixer_ctrl #(
    parameter int PHI_W      = mixer_pkg::PHI_W_DEF,
    parameter int LEN_W      = mixer_pkg::LEN_W_DEF,
    parameter int DEF_PHI    = mixer_pkg::DEF_PHI,
    parameter int RST_CYC    = mixer_pkg::RST_CYC_DEF,
    parameter int SETTLE_CYC = mixer_pkg::SETTLE_CYC_DEF,
    parameter int LED_DIV    = mixer_pkg::LED_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PHI_W-1:0] cfg_phi,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_stop,
    output logic [PHI_W-1:0] phi_inc_o,
    output logic             nco_reset_n,
    output logic             nco_clken,
    output logic             mix_valid,
    output logic             done,
    output logic             cfg_err,
    output logic             led_run
);

    import mixer_pkg::*;

    // state  | meaning
    // IDLE   | waiting for a tuning command, NCO stopped
    // LOAD   | NCO held in reset for RST_CYC cycles
    // SETTLE | NCO running, output masked while pipeline and mean filter fill
    // RUN    | output valid, counting samples

    localparam int TMR_W = $clog2(max2(RST_CYC, SETTLE_CYC)) + 1;

    if (RST_CYC < 1 || SETTLE_CYC < 1 || LED_DIV < 1) begin : g_bad_param
        $error("mixer_ctrl: RST_CYC, SETTLE_CYC and LED_DIV must be >= 1");
    end

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] samp_q, samp_d;
    logic [PHI_W-1:0] phi_q, phi_d;
    logic             ready_q, ready_d;
    logic             rstn_q, rstn_d;
    logic             clken_q, clken_d;
    logic             mv_q, mv_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             take;
    logic             accept;
    logic             reject;

    always_comb begin
        take    = cfg_valid & ready_q & ~cfg_stop;
        accept  = take & (cfg_phi != '0);
        reject  = take & (cfg_phi == '0);
        state_d = state_q;
        tmr_d   = tmr_q;
        len_d   = len_q;
        samp_d  = samp_q;
        phi_d   = phi_q;
        done_d  = 1'b0;
        err_d   = reject;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    phi_d   = cfg_phi;
                    len_d   = cfg_len;
                    tmr_d   = TMR_W'(RST_CYC - 1);
                end
            end
            LOAD: begin
                if (tmr_q == '0) begin
                    state_d = SETTLE;
                    tmr_d   = TMR_W'(SETTLE_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = RUN;
                    samp_d  = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RUN: begin
                samp_d = samp_q + LEN_W'(1);
                // A retune landing on the final sample wins over completion.
                if (accept) begin
                    state_d = LOAD;
                    phi_d   = cfg_phi;
                    len_d   = cfg_len;
                    tmr_d   = TMR_W'(RST_CYC - 1);
                    samp_d  = '0;
                end else if ((len_q != '0) && (samp_d == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_stop && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        ready_d = (state_d == IDLE) || (state_d == RUN);
        rstn_d  = (state_d != LOAD);
        clken_d = (state_d == SETTLE) || (state_d == RUN);
        mv_d    = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            len_q   <= '0;
            samp_q  <= '0;
            phi_q   <= PHI_W'(DEF_PHI);
            ready_q <= 1'b0;
            rstn_q  <= 1'b0;
            clken_q <= 1'b0;
            mv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            len_q   <= len_d;
            samp_q  <= samp_d;
            phi_q   <= phi_d;
            ready_q <= ready_d;
            rstn_q  <= rstn_d;
            clken_q <= clken_d;
            mv_q    <= mv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign phi_inc_o   = phi_q;
    assign nco_reset_n = rstn_q;
    assign nco_clken   = clken_q;
    assign mix_valid   = mv_q;
    assign done        = done_q;
    assign cfg_err     = err_q;

`ifdef MIXER_CTRL_LED_EN
    mixer_led_div #(
        .LED_DIV(LED_DIV)
    ) u_led_div (
        .clk    (clk),
        .rst    (rst),
        .valid_i(mv_q),
        .led_o  (led_run)
    );
`else
    assign led_run = 1'b0;
`endif

endmodule

// File: tb/tb_mixer_ctrl.sv
// Randomized bench for mixer_ctrl against a timeline-based reference model.
module tb_mixer_ctrl;

    localparam int PHI_W      = 16;
    localparam int LEN_W      = 24;
    localparam int DEF_PHI    = 8192;
    localparam int RST_CYC    = 2;
    localparam int SETTLE_CYC = 10;
    localparam int LED_DIV    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_stop = 1'b0;
    logic [PHI_W-1:0] cfg_phi = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_ready;
    logic [PHI_W-1:0] phi_inc_o;
    logic             nco_reset_n;
    logic             nco_clken;
    logic             mix_valid;
    logic             done;
    logic             cfg_err;
    logic             led_run;

    mixer_ctrl #(
        .PHI_W     (PHI_W),
        .LEN_W     (LEN_W),
        .DEF_PHI   (DEF_PHI),
        .RST_CYC   (RST_CYC),
        .SETTLE_CYC(SETTLE_CYC),
        .LED_DIV   (LED_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_phi    (cfg_phi),
        .cfg_len    (cfg_len),
        .cfg_stop   (cfg_stop),
        .phi_inc_o  (phi_inc_o),
        .nco_reset_n(nco_reset_n),
        .nco_clken  (nco_clken),
        .mix_valid  (mix_valid),
        .done       (done),
        .cfg_err    (cfg_err),
        .led_run    (led_run)
    );

    always #100 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: a command accepted in cycle t_acc puts the NCO in reset
    // for cycles t_acc+1..t_acc+RST_CYC, settling for the next SETTLE_CYC cycles,
    // then run sample k (1-based) at cycle t_acc+RST_CYC+SETTLE_CYC+k.
    bit m_active   = 1'b0;
    int m_tacc     = 0;
    int m_len      = 0;
    int m_phi      = DEF_PHI;
    bit m_err_pend = 1'b0;
    int m_vcnt     = 0;
    bit e_ready    = 1'b0;
    int n_done     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phi"},   32'(phi_inc_o),  DEF_PHI);
        chk({tag, "_rstn"},  32'(nco_reset_n), 0);
        chk({tag, "_clken"}, 32'(nco_clken),  0);
        chk({tag, "_mv"},    32'(mix_valid),  0);
        chk({tag, "_ready"}, 32'(cfg_ready),  0);
        chk({tag, "_done"},  32'(done),       0);
        chk({tag, "_err"},   32'(cfg_err),    0);
        chk({tag, "_led"},   32'(led_run),    0);
    endtask

    task automatic eval_and_check();
        int age;
        int rk;
        bit e_rstn, e_clken, e_mv, e_done, e_err, e_led;
        age    = 0;
        e_done = 1'b0;
        e_err  = m_err_pend;
        m_err_pend = 1'b0;
`ifdef MIXER_CTRL_LED_EN
        e_led = ((m_vcnt / LED_DIV) % 2) == 1;
`else
        e_led = 1'b0;
`endif
        if (m_active) begin
            age = cyc - m_tacc;
            rk  = age - RST_CYC - SETTLE_CYC;
            if (m_len != 0 && rk == m_len + 1) begin
                m_active = 1'b0;
                e_done   = 1'b1;
                n_done++;
            end
        end
        if (!m_active) begin
            e_ready = 1; e_rstn = 1; e_clken = 0; e_mv = 0;
        end else if (age <= RST_CYC) begin
            e_ready = 0; e_rstn = 0; e_clken = 0; e_mv = 0;
        end else if (age <= RST_CYC + SETTLE_CYC) begin
            e_ready = 0; e_rstn = 1; e_clken = 1; e_mv = 0;
        end else begin
            e_ready = 1; e_rstn = 1; e_clken = 1; e_mv = 1;
        end
        chk("ready", 32'(cfg_ready),   32'(e_ready));
        chk("rstn",  32'(nco_reset_n), 32'(e_rstn));
        chk("clken", 32'(nco_clken),   32'(e_clken));
        chk("mv",    32'(mix_valid),   32'(e_mv));
        chk("done",  32'(done),        32'(e_done));
        chk("err",   32'(cfg_err),     32'(e_err));
        chk("phi",   32'(phi_inc_o),   m_phi);
        chk("led",   32'(led_run),     32'(e_led));
        if (e_mv) m_vcnt++;
    endtask

    task automatic step(input bit v, input bit s, input logic [PHI_W-1:0] p,
                        input logic [LEN_W-1:0] l);
        cfg_valid = v;
        cfg_stop  = s;
        cfg_phi   = p;
        cfg_len   = l;
        if (s) begin
            m_active = 1'b0;
        end else if (v && e_ready) begin
            if (p != 0) begin
                m_active = 1'b1;
                m_tacc   = cyc;
                m_phi    = int'(p);
                m_len    = int'(l);
            end else begin
                m_err_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        eval_and_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic async_reset(input string tag);
        #50;
        rst = 1'b1;
        #1;
        chk_reset_vals(tag);
        m_active   = 1'b0;
        m_phi      = DEF_PHI;
        m_vcnt     = 0;
        m_err_pend = 1'b0;
        cfg_valid  = 1'b0;
        cfg_stop   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        eval_and_check();
    endtask

    initial begin
        logic [LEN_W-1:0] rl;
        int done_before;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 1;
        eval_and_check();

        // Finite run: phi=4096, len=5.
        done_before = n_done;
        step(1'b1, 1'b0, 16'd4096, 24'd5);
        idle(20);
        chk("len5_done_count", 32'(n_done - done_before), 1);
        chk("len5_phi", 32'(phi_inc_o), 4096);

        // Continuous run, retune after 20 valid cycles.
        done_before = n_done;
        step(1'b1, 1'b0, 16'd1000, 24'd0);
        idle(RST_CYC + SETTLE_CYC + 20);
        step(1'b1, 1'b0, 16'd2048, 24'd0);
        idle(40);
        chk("cont_no_done", 32'(n_done - done_before), 0);
        chk("cont_phi", 32'(phi_inc_o), 2048);
        step(1'b0, 1'b1, '0, '0);
        idle(2);

        // Stop together with a valid command while running.
        step(1'b1, 1'b0, 16'd3000, 24'd0);
        idle(15);
        step(1'b1, 1'b1, 16'd777, 24'd3);
        idle(5);
        chk("stop_phi_held", 32'(phi_inc_o), 3000);

        // Zero phase increment is rejected in IDLE.
        step(1'b1, 1'b0, 16'd0, 24'd4);
        idle(3);

        // Retune coinciding with the final sample of a finite run.
        done_before = n_done;
        step(1'b1, 1'b0, 16'd1234, 24'd3);
        idle(RST_CYC + SETTLE_CYC + 2);
        step(1'b1, 1'b0, 16'd555, 24'd2);
        idle(20);
        chk("coincide_one_done", 32'(n_done - done_before), 1);

        // Asynchronous reset in the middle of SETTLE.
        step(1'b1, 1'b0, 16'd4321, 24'd7);
        idle(RST_CYC + 3);
        async_reset("async");

        for (int i = 0; i < 4000; i++) begin
            case ($urandom % 4)
                0: rl = '0;
                1: rl = 24'd1;
                2: rl = LEN_W'($urandom_range(2, 8));
                default: rl = LEN_W'($urandom_range(9, 40));
            endcase
            if ($urandom % 1000 == 0) begin
                async_reset("rand_async");
            end else begin
                step(($urandom % 10) == 0, ($urandom % 60) == 0,
                     (($urandom % 6) == 0) ? '0 : PHI_W'($urandom), rl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
